regfile: RTL and testbench

Architectural general-purpose register file of the five-stage pipeline. Sink of the write-back triple (write address, write enable, write data) produced by the memory stage via the MEM/WB register, and source of both operands for the decode stage. 32 x 32-bit, two asynchronous read ports, one synchronous write port, r0 hardwired to zero. Storage is not directly resettable, so a sequential clear engine zeroes every register after reset and holds the pipeline off until it completes.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_init.sv | 69 ++++++
 rtl/regfile.sv | 104 ++++++++++
 tb/tb_regfile.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile_pkg                                         |
// | Description : Shared constants, enables and clear-FSM encoding    |
// |               for the architectural register file.               |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
package regfile_pkg;

  localparam int c_NUM_REGS = 32;
  localparam int c_DATA_W   = 32;
  localparam int c_ADDR_W   = 5;

  localparam logic c_WRITE_ENABLE  = 1'b1;
  localparam logic c_WRITE_DISABLE = 1'b0;
  localparam logic c_READ_DISABLE  = 1'b0;

  // rst is active low for this block
  localparam logic c_RST_ACTIVE = 1'b0;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_init.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile_init                                        |
// | Description : Sequential clear engine. After reset it walks       |
// |               r1..r(N-1) writing zero, holding busy high until    |
// |               the last register has been cleared.                 |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module regfile_init
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = c_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // r0 is hardwired, so the walk starts at r1 and ends at the top register
  localparam logic [ADDR_W-1:0] c_FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_nxt;

  // State and clear index registers; reset restarts the walk from r1
  always_ff @(posedge clk) begin
    if (rst == c_RST_ACTIVE) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= c_FIRST_IDX;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Next-state logic: one register cleared per cycle, leave CLEAR after the last
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    clr_we        = c_WRITE_DISABLE;
    case (r_state)
      RF_CLEAR: begin
        clr_we = c_WRITE_ENABLE;
        if (r_clr_idx == c_LAST_IDX) begin
          w_state_nxt = RF_READY;
        end else begin
          w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
        end
      end
      RF_READY: begin
        w_state_nxt = RF_READY;
      end
      default: begin
        w_state_nxt = RF_CLEAR;
      end
    endcase
  end

  assign busy     = (r_state == RF_CLEAR);
  assign clr_addr = r_clr_idx;

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile                                             |
// | Description : 32 x 32 architectural register file. Two async      |
// |               read ports, one sync write port, r0 reads as zero.  |
// |               Contents are zeroed by regfile_init after reset.    |
// |               Option macro REGFILE_BYPASS_EN adds a same-cycle    |
// |               write-to-read bypass on both read ports.            |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module regfile
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = c_NUM_REGS,
  parameter  int DATA_W   = c_DATA_W,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] c_ZERO_ADDR = '0;
  localparam logic [DATA_W-1:0] c_ZERO_DATA = '0;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_ext_we;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;

  // Storage has no reset; r_mem[0] is never written and never read
  logic [DATA_W-1:0] r_mem [NUM_REGS];

  regfile_init #(
    .NUM_REGS (NUM_REGS)
  ) u_init (
    .clk      (clk),
    .rst      (rst),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_ext_we = (we == c_WRITE_ENABLE) && (waddr != c_ZERO_ADDR);

  // Write-port mux: the clear engine owns the array while busy
  always_comb begin
    w_wr_en   = c_WRITE_DISABLE;
    w_wr_addr = waddr;
    w_wr_data = wdata;
    if (rst != c_RST_ACTIVE) begin
      if (w_clr_we == c_WRITE_ENABLE) begin
        w_wr_en   = c_WRITE_ENABLE;
        w_wr_addr = w_clr_addr;
        w_wr_data = c_ZERO_DATA;
      end else if (!w_busy && w_ext_we) begin
        w_wr_en = c_WRITE_ENABLE;
      end
    end
  end

  // Single synchronous write into the array
  always_ff @(posedge clk) begin
    if (w_wr_en == c_WRITE_ENABLE) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Read-port priority: reset, clearing, disabled, r0, bypass, stored value
  function automatic logic [DATA_W-1:0] f_read(
    input logic              re_n,
    input logic [ADDR_W-1:0] raddr_n,
    input logic [DATA_W-1:0] stored
  );
    if (rst == c_RST_ACTIVE || w_busy || re_n == c_READ_DISABLE ||
        raddr_n == c_ZERO_ADDR) begin
      return c_ZERO_DATA;
    end
`ifdef REGFILE_BYPASS_EN
    if (we == c_WRITE_ENABLE && waddr == raddr_n) begin
      return wdata;
    end
`endif
    return stored;
  endfunction

  assign rdata1 = f_read(re1, raddr1, r_mem[raddr1]);
  assign rdata2 = f_read(re2, raddr2, r_mem[raddr2]);
  assign busy   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_regfile                                          |
// | Description : Scoreboard bench for regfile. Stimulus pushes the   |
// |               expected read/busy values of each cycle; a monitor  |
// |               pops and compares on the falling edge. Honours      |
// |               REGFILE_BYPASS_EN in its reference model.           |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic        busy;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        bsy;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          started = 1'b0;
  bit          done = 1'b0;

  // Reference model: cycles of clearing left, and the architectural contents
  int          m_busy = 0;
  logic [31:0] m_mem [32];

  always #5 clk = ~clk;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .busy   (busy)
  );

  function automatic logic [31:0] exp_rd(input logic re_n, input logic [4:0] ra);
    if (!rst || m_busy > 0 || !re_n || ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == ra) return wdata;
`endif
    return m_mem[ra];
  endfunction

  // Apply the edge that just happened to the model, then drive the next cycle
  task automatic cyc(input logic r, input logic w, input logic [4:0] wa,
                     input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                     input logic e2, input logic [4:0] a2);
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_busy = 31;
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
    end else if (we && waddr != 5'd0) begin
      m_mem[waddr] = wdata;
    end
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    e.r1  = exp_rd(re1, raddr1);
    e.r2  = exp_rd(re2, raddr2);
    e.bsy = (m_busy > 0);
    q.push_back(e);
    started = 1'b1;
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, a1, 1'b1, a2);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
  endtask

  // Monitor: outputs are presented every cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("rdata1", rdata1, e.r1);
      check("rdata2", rdata2, e.r2);
      check("busy", {31'h0, busy}, {31'h0, e.bsy});
    end else if (started && !done) begin
      n_checks++;
      $display("FAIL scoreboard_empty t=%0t got=0 entries expected=1", $time);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    // Clear window: writes to r5 must be ignored, reads return 0
    for (int i = 0; i < 31; i++)
      cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd5);
    for (int i = 0; i < 16; i++) idle_read(5'(2 * i), 5'(2 * i + 1));
    // Write then read r7, then with port disabled
    cyc(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
    idle_read(5'd7, 5'd7);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 1'b1, 5'd7);
    // r0 protection
    cyc(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    idle_read(5'd0, 5'd0);
    // Same-cycle write/read of r3 on both ports
    cyc(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 1'b1, 5'd3);
    idle_read(5'd3, 5'd3);
    // Dual port crossed reads
    cyc(1'b1, 1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0);
    cyc(1'b1, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0);
    idle_read(5'd2, 5'd1);
    // Reset at clear cycle 10 restarts a full clear
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd3);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 1'b1, 5'd9);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd3);
    for (int i = 0; i < 33; i++) cyc(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 1'b1, 5'd9);
    for (int i = 0; i < 16; i++) idle_read(5'(2 * i), 5'(2 * i + 1));
    // Randomised traffic with occasional resets and forced bypass hits
    for (int i = 0; i < 500; i++) begin
      logic        r, w, e1, e2;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      r  = ($urandom_range(0, 249) != 0);
      w  = $urandom_range(0, 1) == 1;
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      e1 = $urandom_range(0, 7) != 0;
      e2 = $urandom_range(0, 7) != 0;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      cyc(r, w, wa, wd, e1, a1, e2, a2);
    end
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
